uart_frame_tx: RTL and testbench

- Transmit-side framer for the Pico link. It buffers payload bytes from FPGA logic in a small FIFO.
- On command it emits one frame: SOF, LEN, payload, XOR checksum.
- It sequences bytes into uart_tx through that block's i_tx_dv / o_tx_active / o_tx_done handshake.
- Sits between application logic and the uart_tx instance inside uart_top, in the opposite direction to the rx/lpf path.

---
 rtl/uart_frame_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_frame_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: buffers payload bytes in a FIFO and, on request, emits one
// frame (SOF, LEN, payload, XOR checksum) through the uart_tx handshake.
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_wr_en, i_wr_data         payload FIFO push
//   o_full, o_count            FIFO full flag and occupancy
//   o_overflow                 one-cycle pulse when a write was dropped
//   i_send                     request a frame of the current FIFO contents
//   o_busy, o_frame_done       frame in progress / one-cycle completion pulse
//   o_tx_dv, o_tx_byte         byte strobe and data towards uart_tx
//   i_tx_active, i_tx_done     status from uart_tx
module uart_frame_tx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  SOF_BYTE   = 8'hAA
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr_en,
    input  logic [7:0]                    i_wr_data,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    input  logic                          i_send,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic                          o_tx_dv,
    output logic [7:0]                    o_tx_byte,
    input  logic                          i_tx_active,
    input  logic                          i_tx_done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
    typedef enum logic [1:0] {PH_SOF, PH_LEN, PH_DATA, PH_CSUM} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [7:0]         csum_q, csum_d;
    logic               busy_d, done_d, tx_dv_d;
    logic [7:0]         tx_byte_d;
    logic [7:0]         issue_byte;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q;
    logic               push, pop;

    // FIFO bookkeeping; a push is allowed while full if a pop frees a slot
    assign push    = i_wr_en & (~full_q | pop);
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Byte presented for the current phase
    always_comb begin
        issue_byte = SOF_BYTE;
        case (phase_q)
            PH_SOF:  issue_byte = SOF_BYTE;
            PH_LEN:  issue_byte = 8'(len_q);
            PH_DATA: issue_byte = mem[rd_ptr_q];
            PH_CSUM: issue_byte = csum_q;
        endcase
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        len_d     = len_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        busy_d    = o_busy;
        done_d    = 1'b0;
        tx_dv_d   = 1'b0;
        tx_byte_d = o_tx_byte;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_send) begin
                    // Same-cycle write is not yet in count_q, so it stays for the next frame
                    state_d = ISSUE;
                    phase_d = PH_SOF;
                    len_d   = count_q;
                    rem_d   = count_q;
                    csum_d  = 8'h00;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (!i_tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = issue_byte;
                    state_d   = WAIT_DONE;
                    if (phase_q == PH_LEN || phase_q == PH_DATA) begin
                        csum_d = csum_q ^ issue_byte;
                    end
                    if (phase_q == PH_DATA) begin
                        pop   = 1'b1;
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = ISSUE;
                case (phase_q)
                    PH_SOF:  phase_d = PH_LEN;
                    PH_LEN:  phase_d = (len_q == '0) ? PH_CSUM : PH_DATA;
                    PH_DATA: phase_d = (rem_q == '0) ? PH_CSUM : PH_DATA;
                    PH_CSUM: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            phase_q      <= PH_SOF;
            len_q        <= '0;
            rem_q        <= '0;
            csum_q       <= 8'h00;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_tx_dv      <= 1'b0;
            o_tx_byte    <= 8'h00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            csum_q       <= csum_d;
            o_busy       <= busy_d;
            o_frame_done <= done_d;
            o_tx_dv      <= tx_dv_d;
            o_tx_byte    <= tx_byte_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q      <= count_d;
            full_q       <= (count_d == CNT_W'(FIFO_DEPTH));
            o_overflow   <= i_wr_en & ~push;
        end
    end

    // Payload storage; reset flushes via the pointers only
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_full  = full_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx: behavioural uart_tx responder, queue-based
// frame reference model, handshake monitor, directed and random frames.
module tb_uart_frame_tx;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned BYTE_CYC = 10;
    localparam logic [7:0]  SOF      = 8'hAA;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       send;
    logic       busy;
    logic       frame_done;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;

    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    bit         stretch  = 0;
    logic [7:0] fifo_m[$];
    logic [7:0] got_q[$];

    uart_frame_tx #(.FIFO_DEPTH(DEPTH), .SOF_BYTE(SOF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_full(full), .o_count(count), .o_overflow(overflow), .i_send(send),
        .o_busy(busy), .o_frame_done(frame_done), .o_tx_dv(tx_dv),
        .o_tx_byte(tx_byte), .i_tx_active(tx_active), .i_tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in: captures each strobed byte, busy for BYTE_CYC cycles
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                got_q.push_back(tx_byte);
                tx_active = 1'b1;
                repeat (BYTE_CYC - 1) @(negedge clk);
                tx_done   = 1'b1;
                tx_active = stretch;
                @(negedge clk);
                tx_done = 1'b0;
                if (stretch) begin
                    repeat (5) @(negedge clk);
                    tx_active = 1'b0;
                end
            end
        end
    end

    // Handshake rules, checked on every strobe
    initial begin
        logic prev_dv, prev_done;
        prev_dv   = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_dv) begin
                check_eq("dv_single_cycle", 32'(prev_dv), 32'd0);
                check_eq("dv_while_active", 32'(tx_active), 32'd0);
                check_eq("dv_near_done", 32'(tx_done | prev_done), 32'd0);
            end
            if (frame_done) begin
                done_cnt++;
                check_eq("busy_at_done", 32'(busy), 32'd0);
            end
            prev_dv   = tx_dv;
            prev_done = tx_done;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        logic exp_ovf;
        exp_ovf = (fifo_m.size() >= DEPTH);
        if (!exp_ovf) fifo_m.push_back(b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic send_pulse();
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    // One frame against the reference built from the model FIFO at acceptance
    task automatic run_frame(input bit mid_wr, input logic [7:0] mid_data,
                             input bit resend, input bit same_wr);
        logic [7:0] exp_q[$];
        logic [7:0] b, cs;
        int n, cyc;
        n  = fifo_m.size();
        cs = 8'(n);
        exp_q.push_back(SOF);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            b = fifo_m.pop_front();
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
        got_q.delete();
        done_cnt = 0;
        send = 1'b1;
        if (same_wr && n < DEPTH) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            fifo_m.push_back(wr_data);
        end
        @(negedge clk);
        send  = 1'b0;
        wr_en = 1'b0;
        cyc   = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (mid_wr && cyc == 15 && n + fifo_m.size() < DEPTH) push_byte(mid_data);
            if (resend && cyc == 30) begin
                send_pulse();
                cyc++;
            end
        end
        check_eq("frame_done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("frame_done_pulses", 32'(done_cnt), 32'd1);
        check_eq("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq($sformatf("frame_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check_eq("count_after", 32'(count), 32'(fifo_m.size()));
        check_eq("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int sz, cyc, n;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        send    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_tx_dv", 32'(tx_dv), 32'd0);
        check_eq("rst_tx_byte", 32'(tx_byte), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic three-byte frame: AA 03 01 02 03 03
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        check_eq("count_three", 32'(count), 32'd3);
        run_frame(1'b0, 8'h00, 1'b0, 1'b0);

        // Empty frame: AA 00 00
        run_frame(1'b0, 8'h00, 1'b0, 1'b0);

        // Full FIFO, dropped 17th write, stretched uart_tx
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check_eq("full_flag", 32'(full), 32'd1);
        check_eq("count_full", 32'(count), 32'd16);
        push_byte(8'h55);
        @(negedge clk);
        check_eq("overflow_single", 32'(overflow), 32'd0);
        stretch = 1'b1;
        run_frame(1'b0, 8'h00, 1'b0, 1'b0);
        stretch = 1'b0;

        // Mid-frame write and ignored re-send, then the follow-up frame
        push_byte(8'h11);
        run_frame(1'b1, 8'h22, 1'b1, 1'b0);
        check_eq("mid_count", 32'(count), 32'd1);
        run_frame(1'b0, 8'h00, 1'b0, 1'b0);

        // Random frames
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(0, DEPTH));
            for (int i = 0; i < n; i++) push_byte(8'($urandom));
            stretch = bit'($urandom_range(0, 1));
            run_frame(bit'($urandom_range(0, 1)), 8'($urandom), 1'b0,
                      bit'($urandom_range(0, 1)));
        end
        stretch = 1'b0;

        // Reset during the second payload byte of a four-byte frame
        while (fifo_m.size() > 0) void'(fifo_m.pop_front());
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
        got_q.delete();
        send_pulse();
        cyc = 0;
        while (got_q.size() < 4 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_reach_byte", 32'(got_q.size() >= 4), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_tx_dv", 32'(tx_dv), 32'd0);
        check_eq("midrst_count", 32'(count), 32'd0);
        fifo_m.delete();
        sz = got_q.size();
        repeat (80) @(negedge clk);
        check_eq("midrst_no_more", 32'(got_q.size()), 32'(sz));
        check_eq("midrst_idle", 32'(busy), 32'd0);
        push_byte(8'h5A);
        push_byte(8'hA5);
        run_frame(1'b0, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
